// File: rtl/fpga_robots_game_serial_tx_arb_pkg.sv
// Shared game constants for the serial transmitter: FSM states and
// 115,200 baud 8N1/8N2 framing values.
package fpga_robots_game_serial_tx_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_t;

   localparam int   BAUD_RATE  = 115200;
   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   // Encoding of the round-robin last_grant register
   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/fpga_robots_game_serial_tx_arb_rr_arb2.sv
// Two-requester round-robin arbiter: a lone requester always wins,
// a tie goes to the requester not granted last.
module fpga_robots_game_rr_arb2
   import fpga_robots_game_serial_tx_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_a,
   input  logic req_b,
   output logic grant_a,
   output logic grant_b
);

   logic last_grant;

   always_comb begin
      grant_a = en & req_a & (~req_b | (last_grant == GRANT_B));
      grant_b = en & req_b & ~grant_a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GRANT_B;
      end else if (grant_a) begin
         last_grant <= GRANT_A;
      end else if (grant_b) begin
         last_grant <= GRANT_B;
      end
   end

endmodule

// File: rtl/fpga_robots_game_serial_tx_arb.sv
// Arbitrated serial transmitter: two byte requesters share one
// 8N1/8N2 UART line paced by the baud1 strobe.
module fpga_robots_game_serial_tx_arb
   import fpga_robots_game_serial_tx_arb_pkg::*;
#(
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud1,
   input  logic       req_a,
   input  logic [7:0] data_a,
   output logic       ack_a,
   input  logic       req_b,
   input  logic [7:0] data_b,
   output logic       ack_b,
   output logic       txd,
   output logic       busy
);

   tx_state_t  state;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic       stop_cnt;
   logic       grant_a;
   logic       grant_b;

   fpga_robots_game_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .en      (state == S_IDLE),
      .req_a   (req_a),
      .req_b   (req_b),
      .grant_a (grant_a),
      .grant_b (grant_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         txd      <= IDLE_LEVEL;
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         busy     <= 1'b0;
         shreg    <= 8'h00;
         bit_cnt  <= 3'd0;
         stop_cnt <= 1'b0;
      end else begin
         ack_a <= 1'b0;
         ack_b <= 1'b0;
         unique case (state)
            // baud1 is deliberately ignored here so the start bit is full width
            S_IDLE: begin
               if (grant_a | grant_b) begin
                  shreg <= grant_a ? data_a : data_b;
                  ack_a <= grant_a;
                  ack_b <= grant_b;
                  busy  <= 1'b1;
                  state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (baud1) begin
                  txd   <= 1'b0;
                  state <= S_START;
               end
            end
            S_START: begin
               if (baud1) begin
                  txd     <= shreg[0];
                  bit_cnt <= 3'd0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (baud1) begin
                  if (bit_cnt != 3'(DATA_BITS - 1)) begin
                     shreg   <= {1'b0, shreg[7:1]};
                     txd     <= shreg[1];
                     bit_cnt <= bit_cnt + 3'd1;
                  end else begin
                     txd      <= IDLE_LEVEL;
                     stop_cnt <= 1'b0;
                     state    <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (baud1) begin
                  if (stop_cnt == 1'(STOP_BITS - 1)) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
